// File: rtl/surf_cmd_pkg.sv
// Shared SURF command-path constants and read-FSM state encoding.
// No logic and no timing: constants and types only.
package surf_cmd_pkg;

    localparam logic [7:0] TX_HEADER       = 8'hA6;
    localparam int         NUM_LAB_BUFFERS = 4;
    localparam int         LAB_ID_WIDTH    = 2;
    localparam int         EVENT_ID_WIDTH  = 32;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_LOOKUP = 2'd1,
        RD_ACK    = 2'd2,
        RD_HOLD   = 2'd3
    } rd_state_e;

endpackage

// File: rtl/surf_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// One cycle from inc/clr to count_o; no backpressure, holds at all-ones.
module surf_sat_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 inc_i,
    input  logic                 clr_i,
    output logic [CNT_WIDTH-1:0] count_o
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {CNT_WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/surf_event_id_buffer.sv
// Four-slot event-ID store with req/ack readout and saturating diagnostics.
// Writes visible 1 cycle after strobe; read ack 2 edges after req, then waits for req to drop.
module surf_event_id_buffer
    import surf_cmd_pkg::*;
#(
    parameter int NUM_BUFFERS = 4,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                      clk33_i,
    input  logic                      rst_n_i,
    input  logic                      event_id_wr_i,
    input  logic                      event_id_ok_i,
    input  logic [LAB_ID_WIDTH-1:0]   event_id_buffer_i,
    input  logic [EVENT_ID_WIDTH-1:0] event_id_i,
    input  logic                      rd_req_i,
    input  logic [LAB_ID_WIDTH-1:0]   rd_buffer_i,
    output logic                      rd_ack_o,
    output logic [EVENT_ID_WIDTH-1:0] rd_event_id_o,
    output logic                      rd_hit_o,
    input  logic                      release_i,
    input  logic [LAB_ID_WIDTH-1:0]   release_buffer_i,
    input  logic                      clr_counters_i,
    output logic [NUM_BUFFERS-1:0]    valid_o,
    output logic [CNT_WIDTH-1:0]      bad_sum_count_o,
    output logic [CNT_WIDTH-1:0]      overwrite_count_o,
    output logic [CNT_WIDTH-1:0]      seq_err_count_o
);

    logic [EVENT_ID_WIDTH-1:0] slot_q [NUM_BUFFERS];
    logic [EVENT_ID_WIDTH-1:0] slot_d [NUM_BUFFERS];
    logic [NUM_BUFFERS-1:0]    valid_q, valid_d;
    logic [EVENT_ID_WIDTH-1:0] last_id_q, last_id_d;
    logic                      have_last_q, have_last_d;

    rd_state_e                 state_q, state_d;
    logic [LAB_ID_WIDTH-1:0]   rd_buf_q, rd_buf_d;
    logic [EVENT_ID_WIDTH-1:0] rd_id_q, rd_id_d;
    logic                      rd_hit_q, rd_hit_d;

    logic good_wr, bad_wr, overwrite_inc, seq_inc;

    assign good_wr = event_id_wr_i & event_id_ok_i;
    assign bad_wr  = event_id_wr_i & ~event_id_ok_i;

    // A release of the same slot in the write cycle means the slot was being freed, not clobbered.
    assign overwrite_inc = good_wr && valid_q[event_id_buffer_i] &&
                           !(release_i && (release_buffer_i == event_id_buffer_i));
    assign seq_inc       = good_wr && have_last_q && (event_id_i != last_id_q + 1'b1);

    always_comb begin
        slot_d      = slot_q;
        valid_d     = valid_q;
        last_id_d   = last_id_q;
        have_last_d = have_last_q;
        if (release_i) begin
            valid_d[release_buffer_i] = 1'b0;
        end
        if (good_wr) begin
            slot_d[event_id_buffer_i]  = event_id_i;
            valid_d[event_id_buffer_i] = 1'b1;
            last_id_d                  = event_id_i;
            have_last_d                = 1'b1;
        end
        if (clr_counters_i) begin
            have_last_d = 1'b0;
        end
    end

    // Lookup samples slot/valid before this cycle's write or release lands.
    always_comb begin
        state_d  = state_q;
        rd_buf_d = rd_buf_q;
        rd_id_d  = rd_id_q;
        rd_hit_d = rd_hit_q;
        case (state_q)
            RD_IDLE: begin
                if (rd_req_i) begin
                    state_d  = RD_LOOKUP;
                    rd_buf_d = rd_buffer_i;
                end
            end
            RD_LOOKUP: begin
                state_d  = RD_ACK;
                rd_id_d  = slot_q[rd_buf_q];
                rd_hit_d = valid_q[rd_buf_q];
            end
            RD_ACK:  state_d = RD_HOLD;
            RD_HOLD: begin
                if (!rd_req_i) begin
                    state_d = RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_BUFFERS; i++) begin
                slot_q[i] <= '0;
            end
            valid_q     <= '0;
            last_id_q   <= '0;
            have_last_q <= 1'b0;
            state_q     <= RD_IDLE;
            rd_buf_q    <= '0;
            rd_id_q     <= '0;
            rd_hit_q    <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            valid_q     <= valid_d;
            last_id_q   <= last_id_d;
            have_last_q <= have_last_d;
            state_q     <= state_d;
            rd_buf_q    <= rd_buf_d;
            rd_id_q     <= rd_id_d;
            rd_hit_q    <= rd_hit_d;
        end
    end

    surf_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_bad_sum_cnt (
        .clk_i   (clk33_i),
        .rst_n_i (rst_n_i),
        .inc_i   (bad_wr),
        .clr_i   (clr_counters_i),
        .count_o (bad_sum_count_o)
    );

    surf_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_overwrite_cnt (
        .clk_i   (clk33_i),
        .rst_n_i (rst_n_i),
        .inc_i   (overwrite_inc),
        .clr_i   (clr_counters_i),
        .count_o (overwrite_count_o)
    );

    surf_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_seq_err_cnt (
        .clk_i   (clk33_i),
        .rst_n_i (rst_n_i),
        .inc_i   (seq_inc),
        .clr_i   (clr_counters_i),
        .count_o (seq_err_count_o)
    );

    assign valid_o       = valid_q;
    assign rd_ack_o      = (state_q == RD_ACK);
    assign rd_event_id_o = rd_id_q;
    assign rd_hit_o      = rd_hit_q;

endmodule

// File: tb/tb_surf_event_id_buffer.sv
// Randomized and directed bench for surf_event_id_buffer against a slot/counter reference model.
// All outputs are compared 1 time unit after every rising edge.
module tb_surf_event_id_buffer;

    localparam int CMAX = 255;

    logic        clk33_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        event_id_wr_i = 1'b0;
    logic        event_id_ok_i = 1'b0;
    logic [1:0]  event_id_buffer_i = '0;
    logic [31:0] event_id_i = '0;
    logic        rd_req_i = 1'b0;
    logic [1:0]  rd_buffer_i = '0;
    logic        rd_ack_o;
    logic [31:0] rd_event_id_o;
    logic        rd_hit_o;
    logic        release_i = 1'b0;
    logic [1:0]  release_buffer_i = '0;
    logic        clr_counters_i = 1'b0;
    logic [3:0]  valid_o;
    logic [7:0]  bad_sum_count_o;
    logic [7:0]  overwrite_count_o;
    logic [7:0]  seq_err_count_o;

    surf_event_id_buffer #(.NUM_BUFFERS(4), .CNT_WIDTH(8)) dut (
        .clk33_i           (clk33_i),
        .rst_n_i           (rst_n_i),
        .event_id_wr_i     (event_id_wr_i),
        .event_id_ok_i     (event_id_ok_i),
        .event_id_buffer_i (event_id_buffer_i),
        .event_id_i        (event_id_i),
        .rd_req_i          (rd_req_i),
        .rd_buffer_i       (rd_buffer_i),
        .rd_ack_o          (rd_ack_o),
        .rd_event_id_o     (rd_event_id_o),
        .rd_hit_o          (rd_hit_o),
        .release_i         (release_i),
        .release_buffer_i  (release_buffer_i),
        .clr_counters_i    (clr_counters_i),
        .valid_o           (valid_o),
        .bad_sum_count_o   (bad_sum_count_o),
        .overwrite_count_o (overwrite_count_o),
        .seq_err_count_o   (seq_err_count_o)
    );

    always #15 clk33_i = ~clk33_i;

    // Reference model state
    logic [31:0] m_slot [4];
    logic [3:0]  m_valid;
    logic [31:0] m_last;
    logic        m_have_last;
    int          m_bad, m_ow, m_seq;
    logic        exp_ack;
    logic [31:0] exp_rd_id;
    logic        exp_hit;

    int vectors = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_slot[i] = '0;
        m_valid = '0; m_last = '0; m_have_last = 1'b0;
        m_bad = 0; m_ow = 0; m_seq = 0;
        exp_ack = 1'b0; exp_rd_id = '0; exp_hit = 1'b0;
    endtask

    task automatic model_edge();
        logic good, ow, sq;
        if (!rst_n_i) begin
            model_reset();
            return;
        end
        good = event_id_wr_i && event_id_ok_i;
        ow   = good && m_valid[event_id_buffer_i] &&
               !(release_i && release_buffer_i == event_id_buffer_i);
        sq   = good && m_have_last && (event_id_i != m_last + 32'd1);
        if (clr_counters_i) begin
            m_bad = 0; m_ow = 0; m_seq = 0;
        end else begin
            if (event_id_wr_i && !event_id_ok_i && m_bad < CMAX) m_bad++;
            if (ow && m_ow < CMAX) m_ow++;
            if (sq && m_seq < CMAX) m_seq++;
        end
        if (release_i) m_valid[release_buffer_i] = 1'b0;
        if (good) begin
            m_slot[event_id_buffer_i]  = event_id_i;
            m_valid[event_id_buffer_i] = 1'b1;
            m_last = event_id_i;
            m_have_last = 1'b1;
        end
        if (clr_counters_i) m_have_last = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk33_i);
        model_edge();
        #1;
        check_eq("valid", {28'd0, valid_o}, {28'd0, m_valid});
        check_eq("bad_sum", {24'd0, bad_sum_count_o}, m_bad);
        check_eq("overwrite", {24'd0, overwrite_count_o}, m_ow);
        check_eq("seq_err", {24'd0, seq_err_count_o}, m_seq);
        check_eq("rd_ack", {31'd0, rd_ack_o}, {31'd0, exp_ack});
        check_eq("rd_event_id", rd_event_id_o, exp_rd_id);
        check_eq("rd_hit", {31'd0, rd_hit_o}, {31'd0, exp_hit});
    endtask

    task automatic cyc(input logic wr, input logic ok, input logic [1:0] b, input logic [31:0] id,
                       input logic rel, input logic [1:0] rb, input logic clr);
        event_id_wr_i = wr; event_id_ok_i = ok; event_id_buffer_i = b; event_id_i = id;
        release_i = rel; release_buffer_i = rb; clr_counters_i = clr;
        tick();
        event_id_wr_i = 1'b0; release_i = 1'b0; clr_counters_i = 1'b0;
    endtask

    task automatic good_wr(input logic [1:0] b, input logic [31:0] id);
        cyc(1'b1, 1'b1, b, id, 1'b0, 2'd0, 1'b0);
    endtask

    // Request is sampled at the first edge; the slot contents seen then are what must come back.
    task automatic rd(input logic [1:0] b, input int hold, input logic wr_in_lookup, input logic [31:0] wid);
        logic [31:0] snap_id;
        logic        snap_hit;
        rd_req_i = 1'b1; rd_buffer_i = b;
        tick();
        snap_id = m_slot[b]; snap_hit = m_valid[b];
        rd_buffer_i = ~b;
        exp_ack = 1'b1; exp_rd_id = snap_id; exp_hit = snap_hit;
        if (wr_in_lookup) cyc(1'b1, 1'b1, b, wid, 1'b0, 2'd0, 1'b0);
        else tick();
        exp_ack = 1'b0;
        for (int i = 0; i < hold; i++) tick();
        rd_req_i = 1'b0;
        tick();
    endtask

    initial begin
        model_reset();
        tick(); tick();
        rst_n_i = 1'b1;
        tick();

        // Directed: single write then read
        good_wr(2'd2, 32'h0000_0010);
        check_eq("valid_after_wr", {28'd0, valid_o}, 32'h4);
        rd(2'd2, 1, 1'b0, '0);
        check_eq("rd_id_buf2", rd_event_id_o, 32'h10);

        // Sequence tracking and wrap
        cyc(1'b0, 1'b0, 2'd0, '0, 1'b0, 2'd0, 1'b1);
        good_wr(2'd0, 32'h10); good_wr(2'd1, 32'h11); good_wr(2'd2, 32'h13);
        check_eq("seq_gap", {24'd0, seq_err_count_o}, 32'd1);
        good_wr(2'd0, 32'hFFFF_FFFF); good_wr(2'd1, 32'h0);
        check_eq("seq_wrap", {24'd0, seq_err_count_o}, 32'd2);

        // Bad frames and saturation, then clear
        for (int i = 0; i < 300; i++) cyc(1'b1, 1'b0, 2'd1, 32'hDEAD_0000 + i, 1'b0, 2'd0, 1'b0);
        check_eq("bad_sat", {24'd0, bad_sum_count_o}, 32'd255);
        cyc(1'b1, 1'b0, 2'd1, '0, 1'b0, 2'd0, 1'b1);
        check_eq("bad_clr", {24'd0, bad_sum_count_o}, 32'd0);

        // Overwrite and release/write race on buffer 3
        good_wr(2'd3, 32'h100); good_wr(2'd3, 32'h101);
        check_eq("overwrite1", {24'd0, overwrite_count_o}, 32'd1);
        cyc(1'b1, 1'b1, 2'd3, 32'h102, 1'b1, 2'd3, 1'b0);
        check_eq("rel_wr_same", {28'd0, valid_o}, {28'd0, 4'b1000 | m_valid});

        // Empty read, long hold, write during lookup
        cyc(1'b0, 1'b0, 2'd0, '0, 1'b1, 2'd0, 1'b0);
        rd(2'd0, 10, 1'b1, 32'h5555);
        check_eq("lookup_old", {31'd0, rd_hit_o}, 32'd0);

        // Reset during lookup
        rd_req_i = 1'b1; rd_buffer_i = 2'd3;
        tick();
        rst_n_i = 1'b0;
        model_reset();
        #1;
        check_eq("rst_ack", {31'd0, rd_ack_o}, 32'd0);
        check_eq("rst_valid", {28'd0, valid_o}, 32'd0);
        check_eq("rst_rd_id", rd_event_id_o, 32'd0);
        tick(); tick();
        rd_req_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        tick();
        good_wr(2'd1, 32'hABCD_0001);
        rd(2'd1, 2, 1'b0, '0);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                rd(2'($urandom_range(0, 3)), $urandom_range(1, 4),
                   1'($urandom_range(0, 1)), $urandom);
            end else begin
                cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 9) < 7) ? m_last + 32'd1 : 32'($urandom),
                    ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 31) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
